// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: resolves E0/F0 prefixes, tracks Shift/Caps Lock,
// translates to ASCII and queues key events in a small FWFT FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    code_in,
  input  logic                          code_valid,
  output logic [18:0]                   evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          caps_lock,
  output logic                          overflow,
  output logic                          proto_err,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_E0 = 2'd1, S_F0 = 2'd2, S_E0F0 = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic            caps_q, caps_d, caps_held_q, caps_held_d;
  logic            dec_valid_q, dec_valid_d, dec_brk_q, dec_brk_d, dec_ext_q, dec_ext_d;
  logic            dec_shift_q, dec_shift_d, dec_caps_q, dec_caps_d;
  logic [7:0]      dec_code_q, dec_code_d;
  logic [18:0]     mem_q [FIFO_DEPTH];
  logic [18:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [18:0]     head_q, head_d;
  logic            valid_q, valid_d, ovf_q, ovf_d, perr_q, perr_d;

  logic            is_e0, is_f0, is_err_code, is_ignored;
  logic            emit, emit_brk, emit_ext, perr_set;
  logic            pop, full, do_push, drop;
  logic [18:0]     push_data;

  function automatic logic [7:0] ascii_lookup(input logic [7:0] code, input logic ext,
                                              input logic shift, input logic caps);
    logic [7:0] r;
    r = 8'h00;
    if (ext) begin
      r = (code == 8'h5A) ? 8'h0D : 8'h00;
    end else begin
      case (code)
        8'h1C: r = 8'h61;  8'h32: r = 8'h62;  8'h21: r = 8'h63;  8'h23: r = 8'h64;
        8'h24: r = 8'h65;  8'h2B: r = 8'h66;  8'h34: r = 8'h67;  8'h33: r = 8'h68;
        8'h43: r = 8'h69;  8'h3B: r = 8'h6A;  8'h42: r = 8'h6B;  8'h4B: r = 8'h6C;
        8'h3A: r = 8'h6D;  8'h31: r = 8'h6E;  8'h44: r = 8'h6F;  8'h4D: r = 8'h70;
        8'h15: r = 8'h71;  8'h2D: r = 8'h72;  8'h1B: r = 8'h73;  8'h2C: r = 8'h74;
        8'h3C: r = 8'h75;  8'h2A: r = 8'h76;  8'h1D: r = 8'h77;  8'h22: r = 8'h78;
        8'h35: r = 8'h79;  8'h1A: r = 8'h7A;
        8'h16: r = shift ? 8'h21 : 8'h31;
        8'h1E: r = shift ? 8'h40 : 8'h32;
        8'h26: r = shift ? 8'h23 : 8'h33;
        8'h25: r = shift ? 8'h24 : 8'h34;
        8'h2E: r = shift ? 8'h25 : 8'h35;
        8'h36: r = shift ? 8'h5E : 8'h36;
        8'h3D: r = shift ? 8'h26 : 8'h37;
        8'h3E: r = shift ? 8'h2A : 8'h38;
        8'h46: r = shift ? 8'h28 : 8'h39;
        8'h45: r = shift ? 8'h29 : 8'h30;
        8'h29: r = 8'h20;
        8'h5A: r = 8'h0D;
        8'h66: r = 8'h08;
        8'h0D: r = 8'h09;
        8'h76: r = 8'h1B;
        default: r = 8'h00;
      endcase
      // Only letters land in a..z, so the case fold can key off the value.
      if ((r >= 8'h61) && (r <= 8'h7A) && (shift ^ caps)) begin
        r = r - 8'h20;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign is_e0       = (code_in == 8'hE0);
  assign is_f0       = (code_in == 8'hF0);
  assign is_err_code = (code_in == 8'h00) || (code_in == 8'hFF);
  assign is_ignored  = (code_in == 8'hAA) || (code_in == 8'hFA) ||
                       (code_in == 8'hEE) || (code_in == 8'hFE);

  // Prefix FSM and its abandonment timer.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    perr_set = 1'b0;
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;
    if (code_valid) begin
      tcnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (is_e0)            state_d  = S_E0;
          else if (is_f0)       state_d  = S_F0;
          else if (is_err_code) perr_set = 1'b1;
          else                  emit     = !is_ignored;
        end
        S_E0: begin
          if (is_f0)      state_d  = S_E0F0;
          else if (is_e0) perr_set = 1'b1;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_F0, S_E0F0: begin
          state_d = S_IDLE;
          if (is_e0 || is_f0) perr_set = 1'b1;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state_q == S_E0F0);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tcnt_d = '0;
    end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
      perr_set = 1'b1;
      state_d  = S_IDLE;
      tcnt_d   = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Modifier tracking and capture of the event into the decode stage.
  always_comb begin
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (emit && !emit_ext) begin
      case (code_in)
        8'h12: shift_l_d = !emit_brk;
        8'h59: shift_r_d = !emit_brk;
        8'h58: begin
          caps_held_d = !emit_brk;
          caps_d      = caps_q ^ (!emit_brk && !caps_held_q);
        end
        default: caps_d = caps_q;
      endcase
    end else begin
      caps_d = caps_q;
    end
    dec_valid_d = emit;
    if (emit) begin
      dec_brk_d   = emit_brk;
      dec_ext_d   = emit_ext;
      dec_shift_d = shift_l_q | shift_r_q;
      dec_caps_d  = caps_q;
      dec_code_d  = code_in;
    end else begin
      dec_brk_d   = dec_brk_q;
      dec_ext_d   = dec_ext_q;
      dec_shift_d = dec_shift_q;
      dec_caps_d  = dec_caps_q;
      dec_code_d  = dec_code_q;
    end
  end

  assign push_data = {dec_brk_q, dec_ext_q, dec_shift_q, dec_code_q,
                      ascii_lookup(dec_code_q, dec_ext_q, dec_shift_q, dec_caps_q)};
  assign pop       = valid_q && evt_ready;
  assign full      = (count_q == LW'(FIFO_DEPTH));
  assign do_push   = dec_valid_q && (!full || pop);
  assign drop      = dec_valid_q && full && !pop;

  // Event FIFO with the head kept in its own register.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    else         mem_d = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + LW'(do_push) - LW'(pop);
    valid_d  = (count_d != '0);
    if (count_d == '0)          head_d = '0;
    else if (count_q == '0)     head_d = push_data;
    else if (pop)               head_d = (count_q == LW'(1)) ? push_data
                                                             : mem_q[rd_ptr_q + AW'(1)];
    else                        head_d = head_q;
    ovf_d  = drop     ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    perr_d = perr_set ? 1'b1 : (err_clr ? 1'b0 : perr_q);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_brk_q   <= 1'b0;
      dec_ext_q   <= 1'b0;
      dec_shift_q <= 1'b0;
      dec_caps_q  <= 1'b0;
      dec_code_q  <= 8'h00;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      dec_valid_q <= dec_valid_d;
      dec_brk_q   <= dec_brk_d;
      dec_ext_q   <= dec_ext_d;
      dec_shift_q <= dec_shift_d;
      dec_caps_q  <= dec_caps_d;
      dec_code_q  <= dec_code_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  assign evt_data   = head_q;
  assign evt_valid  = valid_q;
  assign fifo_level = count_q;
  assign caps_lock  = caps_q;
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed and randomized bench for ps2_scancode_decoder against a
// keymap-table reference model with an expected-event queue.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 8;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        rst, code_valid, evt_ready, err_clr;
  logic [7:0]  code_in;
  logic [18:0] evt_data;
  logic        evt_valid, caps_lock, overflow, proto_err;
  logic [3:0]  fifo_level;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .fifo_level(fifo_level), .caps_lock(caps_lock), .overflow(overflow),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                   8'h46, 8'h45};
  logic [7:0] special_codes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] modifier_codes [3] = '{8'h12, 8'h59, 8'h58};
  string dig_plain = "1234567890";
  string dig_shift = "!@#$%^&*()";

  // reference model state
  logic        m_ext, m_brk, m_shl, m_shr, m_caps, m_held, m_perr;
  int          m_tcnt;
  logic [18:0] exp_q [$];
  logic [18:0] last_pop;
  logic [7:0]  rb;
  logic        rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic ext,
                                             input logic sh, input logic caps);
    if (ext) return (c == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return ((sh ^ caps) ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return sh ? 8'(dig_shift[i]) : 8'(dig_plain[i]);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    if (c == 8'h0D) return 8'h09;
    if (c == 8'h76) return 8'h1B;
    return 8'h00;
  endfunction

  task automatic model_emit(input logic [7:0] b);
    logic sh;
    sh = m_shl | m_shr;
    exp_q.push_back({m_brk, m_ext, sh, b, model_ascii(b, m_ext, sh, m_caps)});
    if (!m_ext) begin
      if (b == 8'h12) m_shl = !m_brk;
      if (b == 8'h59) m_shr = !m_brk;
      if (b == 8'h58) begin
        if (m_brk) m_held = 1'b0;
        else begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1'b1;
        end
      end
    end
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic pending;
    pending = m_ext || m_brk;
    if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin
        m_perr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0 && m_ext) m_perr = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else m_brk = 1'b1;
    end else if (!pending && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
      m_tcnt = 0;
    end else if (!pending && (b == 8'h00 || b == 8'hFF)) begin
      m_perr = 1'b1;
    end else begin
      model_emit(b);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
    code_valid = v; code_in = b; evt_ready = rdy; err_clr = clr;
    if (evt_valid && rdy) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        last_pop = evt_data;
        chk("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
      end
    end
    if (clr) m_perr = 1'b0;
    if (v) begin
      model_byte(b);
      m_tcnt = 0;
    end else if (m_ext || m_brk) begin
      m_tcnt++;
      if (m_tcnt == TO) begin
        m_perr = 1'b1; m_ext = 1'b0; m_brk = 1'b0; m_tcnt = 0;
      end
    end
    @(posedge clk); #1;
    code_valid = 1'b0; err_clr = 1'b0;
    chk("caps_lock", 32'(caps_lock), 32'(m_caps));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
  endtask

  task automatic do_reset(input logic v, input logic [7:0] b);
    rst = 1'b1; code_valid = v; code_in = b; evt_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; code_valid = 1'b0;
    m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_held = 0; m_perr = 0;
    m_tcnt = 0;
    exp_q.delete();
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_evt_data", 32'(evt_data), 32'd0);
    chk("rst_caps_lock", 32'(caps_lock), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (exp_q.size() != 0 || evt_valid); i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_done", 32'(exp_q.size() == 0 && !evt_valid), 32'd1);
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  task automatic feed(input logic [7:0] b, input logic rdy);
    step(1'b1, b, rdy, 1'b0);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 9))
      0:       return 8'hE0;
      1:       return 8'hF0;
      2, 3:    return letter_codes[$urandom_range(0, 25)];
      4:       return digit_codes[$urandom_range(0, 9)];
      5:       return modifier_codes[$urandom_range(0, 2)];
      6:       return special_codes[$urandom_range(0, 4)];
      7:       return 8'($urandom_range(0, 255));
      default: return letter_codes[$urandom_range(0, 25)];
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = 8'h00; evt_ready = 1'b0; err_clr = 1'b0;
    last_pop = '0;
    @(posedge clk); #1;
    do_reset(1'b0, 8'h00);

    // plain make then break, with latency observed while the consumer stalls
    feed(8'h1C, 1'b0);
    chk("lat_edge1_valid", 32'(evt_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_edge2_valid", 32'(evt_valid), 32'd1);
    chk("make_1c_head", 32'(evt_data), 32'({1'b0, 1'b0, 1'b0, 8'h1C, 8'h61}));
    chk("make_1c_level", 32'(fifo_level), 32'd1);
    feed(8'hF0, 1'b0); feed(8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("break_1c_level", 32'(fifo_level), 32'd2);
    drain();
    chk("break_1c_data", 32'(last_pop), 32'({1'b1, 1'b0, 1'b0, 8'h1C, 8'h61}));

    // shift handling
    feed(8'h12, 1'b0); feed(8'h1E, 1'b0); feed(8'hF0, 1'b0); feed(8'h12, 1'b0); feed(8'h1E, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0); step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("shift_level", 32'(fifo_level), 32'd4);
    chk("shift_make_head", 32'(evt_data), 32'({1'b0, 1'b0, 1'b0, 8'h12, 8'h00}));
    drain();
    chk("shift_last_2", 32'(last_pop), 32'({1'b0, 1'b0, 1'b0, 8'h1E, 8'h32}));

    // caps lock with typematic repeat
    feed(8'h58, 1'b1);
    chk("caps_after_first", 32'(caps_lock), 32'd1);
    feed(8'h58, 1'b1); feed(8'hF0, 1'b1); feed(8'h58, 1'b1); feed(8'h1C, 1'b1);
    drain();
    chk("caps_held_on", 32'(caps_lock), 32'd1);
    chk("caps_letter_A", 32'(last_pop), 32'({1'b0, 1'b0, 1'b0, 8'h1C, 8'h41}));

    // extended make and break
    feed(8'hE0, 1'b0); feed(8'h5A, 1'b0); feed(8'hE0, 1'b0); feed(8'hF0, 1'b0); feed(8'h75, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0); step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ext_enter_head", 32'(evt_data), 32'({1'b0, 1'b1, 1'b0, 8'h5A, 8'h0D}));
    chk("ext_level", 32'(fifo_level), 32'd2);
    drain();
    chk("ext_break_75", 32'(last_pop), 32'({1'b1, 1'b1, 1'b0, 8'h75, 8'h00}));

    // prefix timeout
    step(1'b0, 8'h00, 1'b1, 1'b1);
    feed(8'hE0, 1'b1);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("timeout_not_yet", 32'(proto_err), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("timeout_fired", 32'(proto_err), 32'd1);
    feed(8'h1C, 1'b1);
    drain();
    chk("after_timeout_make", 32'(last_pop), 32'({1'b0, 1'b0, 1'b0, 8'h1C, 8'h41}));

    // overflow, err_clr priority, push and pop together while full
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) feed(8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0); step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovf_set", 32'(overflow), 32'd1);
    void'(exp_q.pop_back());  // the ninth event found the FIFO full
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    feed(8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    void'(exp_q.pop_back());
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared2", 32'(overflow), 32'd0);
    feed(8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_pushpop_level", 32'(fifo_level), 32'(DEPTH));
    chk("full_pushpop_no_ovf", 32'(overflow), 32'd0);
    drain();
    chk("ovf_after_drain", 32'(overflow), 32'd0);

    // reset in the middle of a break sequence, with a byte arriving during reset
    feed(8'hF0, 1'b0);
    do_reset(1'b1, 8'h1C);
    feed(8'h1C, 1'b1);
    drain();
    chk("post_reset_make", 32'(last_pop), 32'({1'b0, 1'b0, 1'b0, 8'h1C, 8'h61}));

    // randomized traffic against the reference model
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      rb = pick_byte();
      rv = ($urandom_range(0, 2) != 0) && (exp_q.size() <= DEPTH - 2);
      step(rv, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    drain();
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
